// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message scheduler: takes a 16-word block and emits W0..W(ROUNDS-1).
// WORD_WIDTH=32 gives the SHA-256 schedule (64 rounds); WORD_WIDTH=64 gives
// the SHA-512 schedule (80 rounds).
// Optional macro SHA2_SCHED_PIPE_EN adds a register that precomputes
// s0(W[t-15]) + W[t-16] one shift early, so that the emit path has one
// adder fewer. Port behaviour and cycle timing are the same either way.
module sha2_msg_scheduler #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_word,
  output logic [6:0]            out_index,
  output logic                  out_last
);

  localparam int ROUNDS = (WORD_WIDTH == 64) ? 80 : 64;
  localparam logic [6:0] LAST_RND = 7'(ROUNDS - 1);

  if (WORD_WIDTH != 32 && WORD_WIDTH != 64) begin : g_bad_width
    $error("sha2_msg_scheduler: WORD_WIDTH must be 32 or 64");
  end

  typedef enum logic {LOAD = 1'b0, EMIT = 1'b1} state_t;

  state_t                            state, state_nxt;
  logic [6:0]                        cnt, cnt_nxt;
  logic [15:0][WORD_WIDTH-1:0]       wbuf;   // [0] oldest = W[t-16] during emit
  logic                              shift;
  logic [WORD_WIDTH-1:0]             new_word;
  logic [WORD_WIDTH-1:0]             sched_word;

  function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x,
                                                 input int n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig0(input logic [WORD_WIDTH-1:0] x);
    if (WORD_WIDTH == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else                  return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig1(input logic [WORD_WIDTH-1:0] x);
    if (WORD_WIDTH == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else                  return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef SHA2_SCHED_PIPE_EN
  // After any shift, buf[1] moves to buf[0] and buf[2] to buf[1], so loading
  // pre from the pre-shift entries leaves it equal to s0(buf[1]) + buf[0].
  logic [WORD_WIDTH-1:0] pre;

  // Precompute register, refreshed on every shift (load or emit).
  always_ff @(posedge clk) begin
    if (rst)        pre <= '0;
    else if (shift) pre <= sig0(wbuf[2]) + wbuf[1];
  end

  assign sched_word = sig1(wbuf[14]) + wbuf[9] + pre;
`else
  assign sched_word = sig1(wbuf[14]) + wbuf[9] + sig0(wbuf[1]) + wbuf[0];
`endif

  // State and round counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOAD;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Word buffer; never cleared between blocks, the next load overwrites it.
  always_ff @(posedge clk) begin
    if (rst)        wbuf <= '0;
    else if (shift) wbuf <= {new_word, wbuf[15:1]};
  end

  // Next state, shift control and handshake outputs.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shift     = 1'b0;
    new_word  = in_word;
    in_ready  = (state == LOAD);
    out_valid = (state == EMIT);
    case (state)
      LOAD: begin
        if (in_valid) begin
          shift = 1'b1;
          if (cnt == 7'd15) begin
            state_nxt = EMIT;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          shift    = 1'b1;
          new_word = sched_word;
          if (cnt == LAST_RND) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
      end
      default: state_nxt = LOAD;
    endcase
    // Flush wins over any handshake on the same edge and drops its data.
    if (flush) begin
      state_nxt = LOAD;
      cnt_nxt   = '0;
      shift     = 1'b0;
    end
  end

  assign out_word  = out_valid ? wbuf[0] : '0;
  assign out_index = out_valid ? cnt : '0;
  assign out_last  = out_valid && (cnt == LAST_RND);

endmodule

// File: tb/tb_sha2_msg_scheduler.sv
// Directed bench for sha2_msg_scheduler: SHA-256 instance (abc block, other
// blocks, random backpressure, flush, reset) and a SHA-512 instance (abc).
module tb_sha2_msg_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  // 32-bit instance
  logic        flush = 1'b0, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_last;
  logic [31:0] in_word = '0, out_word;
  logic [6:0]  out_index;
  // 64-bit instance
  logic        flush_l = 1'b0, in_valid_l = 1'b0, in_ready_l, out_valid_l, out_ready_l = 1'b0, out_last_l;
  logic [63:0] in_word_l = '0, out_word_l;
  logic [6:0]  out_index_l;

  always #5 clk = ~clk;

  sha2_msg_scheduler #(.WORD_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_index(out_index), .out_last(out_last));

  sha2_msg_scheduler #(.WORD_WIDTH(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush_l), .in_valid(in_valid_l), .in_ready(in_ready_l),
    .in_word(in_word_l), .out_valid(out_valid_l), .out_ready(out_ready_l),
    .out_word(out_word_l), .out_index(out_index_l), .out_last(out_last_l));

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model (FIPS 180-4 indexing).
  logic [31:0] blk32 [16];
  logic [31:0] exp32 [64];
  logic [63:0] blk64 [16];
  logic [63:0] exp64 [80];

  function automatic logic [31:0] m_s0_32(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] m_s1_32(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  function automatic logic [63:0] m_s0_64(input logic [63:0] x);
    return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
  endfunction
  function automatic logic [63:0] m_s1_64(input logic [63:0] x);
    return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
  endfunction

  task automatic build32();
    for (int t = 0; t < 64; t++)
      exp32[t] = (t < 16) ? blk32[t]
               : m_s1_32(exp32[t-2]) + exp32[t-7] + m_s0_32(exp32[t-15]) + exp32[t-16];
  endtask

  task automatic build64();
    for (int t = 0; t < 80; t++)
      exp64[t] = (t < 16) ? blk64[t]
               : m_s1_64(exp64[t-2]) + exp64[t-7] + m_s0_64(exp64[t-15]) + exp64[t-16];
  endtask

  task automatic set_abc32();
    for (int i = 0; i < 16; i++) blk32[i] = '0;
    blk32[0]  = 32'h61626380;
    blk32[15] = 32'h00000018;
    build32();
  endtask

  // Feed n words from blk32; out_ready held high to show LOAD ignores it.
  task automatic load32(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_word  = blk32[i];
      chk($sformatf("in_ready32[%0d]", i), in_ready, 1);
      chk($sformatf("load_ov32[%0d]", i), out_valid, 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  // Consume words until stop_at handshakes; rnd toggles out_ready randomly.
  task automatic emit32(input bit rnd, input int stop_at, input bit abc);
    int idx = 0;
    int cyc = 0;
    while (idx < stop_at && cyc < 2000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      chk("emit_valid32", out_valid, 1);
      chk("emit_index32", out_index, idx);
      chk("emit_hold32", out_word, exp32[idx]);
      if (out_ready) begin
        chk($sformatf("last32[%0d]", idx), out_last, idx == 63);
        if (abc && idx == 16) chk("abc_w16", out_word, 32'h61626380);
        if (abc && idx == 17) chk("abc_w17", out_word, 32'h000F0000);
        if (abc && idx == 63) chk("abc_w63", out_word, 32'h12B1EDEB);
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    if (idx < stop_at) chk("emit32_timeout", idx, stop_at);
  endtask

  task automatic check_idle32(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
  endtask

  task automatic full_run32(input bit rnd, input bit abc);
    load32(16);
    chk("load_done_ov32", out_valid, 1);
    chk("load_done_ir32", in_ready, 0);
    emit32(rnd, 64, abc);
    out_ready = 1'b0;
    check_idle32("after_run32");
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_word", out_word, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_in_ready64", in_ready_l, 1);
    chk("rst_out_valid64", out_valid_l, 0);
    rst = 1'b0;
    @(negedge clk);

    // abc, out_ready high, with a hold phase and ignored in_valid in EMIT
    set_abc32();
    load32(16);
    chk("abc_ov", out_valid, 1);
    in_valid = 1'b1;
    in_word  = 32'hDEADBEEF;
    repeat (3) begin
      @(negedge clk);
      chk("hold_index", out_index, 0);
      chk("hold_word", out_word, exp32[0]);
      chk("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    emit32(1'b0, 64, 1'b1);
    out_ready = 1'b0;
    check_idle32("abc_end");

    // abc with random backpressure
    full_run32(1'b1, 1'b1);

    // flush at index 20, then a different block
    load32(16);
    emit32(1'b0, 20, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready = 1'b0;
    check_idle32("flush_emit");
    for (int i = 0; i < 16; i++) blk32[i] = 32'h9E3779B9 * (i + 1);
    build32();
    full_run32(1'b0, 1'b0);

    // flush after 7 loaded words with a simultaneous in-handshake
    for (int i = 0; i < 16; i++) blk32[i] = ~(32'h0F1E2D3C + 32'h11111111 * i);
    build32();
    load32(7);
    in_valid = 1'b1;
    in_word  = blk32[7];
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check_idle32("flush_load");
    full_run32(1'b1, 1'b0);

    // reset mid-emit, then abc again
    set_abc32();
    load32(16);
    emit32(1'b0, 30, 1'b1);
    out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_out_word", out_word, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_out_index", out_index, 0);
    full_run32(1'b0, 1'b1);

    // SHA-512 abc block
    for (int i = 0; i < 16; i++) blk64[i] = '0;
    blk64[0]  = 64'h6162638000000000;
    blk64[15] = 64'h18;
    build64();
    for (int i = 0; i < 16; i++) begin
      in_valid_l = 1'b1;
      in_word_l  = blk64[i];
      chk($sformatf("in_ready64[%0d]", i), in_ready_l, 1);
      @(negedge clk);
    end
    in_valid_l = 1'b0;
    begin
      int idx = 0;
      int cyc = 0;
      while (idx < 80 && cyc < 2000) begin
        out_ready_l = 1'($urandom_range(0, 1));
        chk("emit_valid64", out_valid_l, 1);
        chk("emit_index64", out_index_l, idx);
        if (out_ready_l) begin
          chk($sformatf("w64[%0d]", idx), out_word_l, exp64[idx]);
          chk($sformatf("last64[%0d]", idx), out_last_l, idx == 79);
          if (idx == 16) chk("abc512_w16", out_word_l, 64'h6162638000000000);
          if (idx == 17) chk("abc512_w17", out_word_l, 64'h00030000000000C0);
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
      if (idx < 80) chk("emit64_timeout", idx, 80);
    end
    out_ready_l = 1'b0;
    chk("end64_in_ready", in_ready_l, 1);
    chk("end64_out_valid", out_valid_l, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sha2_msg_scheduler.md
SHA2_MSG_SCHEDULER -- requirements
Module: sha2_msg_scheduler

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 32: scheduler word width; 32 selects SHA-256, 64 selects SHA-512.
REQ-002 The block SHALL use localparam ROUNDS: 64 when WORD_WIDTH=32, 80 when WORD_WIDTH=64; any other WORD_WIDTH SHALL fail elaboration.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 flush  input  1  abort the current block and return to LOAD.
REQ-006 in_valid  input  1  in_word is valid.
REQ-007 in_ready  output  1  block accepts a message word.
REQ-008 in_word  input  WORD_WIDTH  message block word, W0 first.
REQ-009 out_valid  output  1  out_word holds scheduled word W[out_index].
REQ-010 out_ready  input  1  consumer (compressor) takes out_word.
REQ-011 out_word  output  WORD_WIDTH  scheduled word Wt.
REQ-012 out_index  output  7  round index t, 0..ROUNDS-1.
REQ-013 out_last  output  1  high while out_valid and out_index=ROUNDS-1.

Function
REQ-014 The block SHALL hold a 16-entry WORD_WIDTH shift buffer buf[0..15], buf[0] oldest, plus a 7-bit counter cnt and a 1-bit state {LOAD, EMIT}.
REQ-015 A shift SHALL set buf[i]<=buf[i+1] for i=0..14 and buf[15]<=new word.
REQ-016 In LOAD: in_ready=1, out_valid=0; each in_valid&in_ready cycle SHALL shift with new word = in_word and increment cnt.
REQ-017 The 16th accepted word (cnt=15) SHALL move the block to EMIT with cnt<=0; out_valid SHALL rise the next cycle, so latency from the last in-handshake to out_valid is 1 cycle.
REQ-018 In EMIT: in_ready=0, out_valid=1, out_word=buf[0], out_index=cnt.
REQ-019 Each out_valid&out_ready cycle SHALL shift with new word = s1(buf[14]) + buf[9] + s0(buf[1]) + buf[0], modulo 2^WORD_WIDTH, and increment cnt.
REQ-020 For WORD_WIDTH=32: s0 = ROTR7^ROTR18^SHR3 and s1 = ROTR17^ROTR19^SHR10.
REQ-021 For WORD_WIDTH=64: s0 = ROTR1^ROTR8^SHR7 and s1 = ROTR19^ROTR61^SHR6.
REQ-022 out_ready low in EMIT SHALL hold buf, cnt, out_word and out_index unchanged for any number of cycles.
REQ-023 The handshake at cnt=ROUNDS-1 SHALL return the block to LOAD with cnt<=0, and in_ready SHALL be 1 in the next cycle.
REQ-024 The buffer SHALL NOT be cleared between blocks; the next load overwrites it.
REQ-025 flush=1 SHALL force LOAD with cnt<=0 on that edge, overriding any simultaneous in- or out-handshake, whose data SHALL be discarded.
REQ-026 in_valid in EMIT and out_ready in LOAD SHALL have no effect.

Reset
REQ-027 rst=1 SHALL set state=LOAD, cnt=0, all buf entries to 0 and the pipeline register to 0, giving outputs in_ready=1, out_valid=0, out_word=0, out_index=0 and out_last=0.
REQ-028 rst SHALL take priority over flush and all handshakes, including mid-load and mid-emit.

Configuration
REQ-029 With macro SHA2_SCHED_PIPE_EN defined, a register pre SHALL be loaded on every shift with s0(buf[2])+buf[1].
REQ-030 In that case the new EMIT word SHALL be s1(buf[14])+buf[9]+pre, removing one adder from the critical path.
REQ-031 Port-level behaviour and cycle timing SHALL be identical with and without SHA2_SCHED_PIPE_EN.
REQ-032 Without SHA2_SCHED_PIPE_EN, no pre register SHALL exist and the new word SHALL be computed as in REQ-019.

Verification
REQ-033 Case: WORD_WIDTH=32, load "abc" block (W0=0x61626380, W1..W14=0, W15=0x00000018), out_ready=1 -> out_word W16=0x61626380, W17=0x000F0000, W63=0x12B1EDEB, out_last high only at index 63, in_ready=1 on the following cycle.
REQ-034 Case: same block with out_ready toggling randomly -> the identical 64-word sequence, no word duplicated or skipped, out_index strictly sequential.
REQ-035 Case: WORD_WIDTH=64 with SHA-512 "abc" block (W0=0x6162638000000000, W15=0x18) -> 80 words matching the FIPS 180-4 reference model and out_last at index 79.
REQ-036 Case: flush asserted at index 20 during EMIT, and separately after 7 loaded words -> next cycle in_ready=1, out_valid=0; a fresh 16-word load then yields the correct schedule.
REQ-037 Case: rst pulsed mid-emit -> next cycle out_valid=0, out_word=0, in_ready=1; re-run REQ-033 passes.
REQ-038 Case: REQ-033 through REQ-037 run with and without SHA2_SCHED_PIPE_EN -> cycle-identical port traces.
